// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sequencer sharing one multi-cycle divider among N requesters.
// Optional macro DIV_ARBITER_ZERO_CHECK_EN: zero divisors bypass the divider with rsp_err=1.
module div_arbiter #(
    parameter int K = 32,
    parameter int N = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N*K-1:0] req_a,
    input  logic [N*K-1:0] req_b,
    output logic [N-1:0]   rsp_valid,
    output logic [K-1:0]   rsp_quo,
    output logic [K-1:0]   rsp_rem,
    output logic           rsp_err,
    output logic           div_start,
    output logic [K-1:0]   div_a,
    output logic [K-1:0]   div_b,
    input  logic           div_done,
    input  logic [K-1:0]   div_quo,
    input  logic [K-1:0]   div_rem
);

    localparam int IW = $clog2(N);
    localparam logic [N-1:0] ONE = N'(1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] owner;
    logic [IW-1:0] gidx;
    logic          found;
    logic [N-1:0]  grant;
    logic [K-1:0]  sel_a;
    logic [K-1:0]  sel_b;
    logic          hs;
    logic          zero_byp;

    // Search upward from ptr+1 with wrap; the first valid requester wins.
    always_comb begin : pick
        int j;
        j     = 0;
        gidx  = '0;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!found && req_valid[IW'(j)]) begin
                found = 1'b1;
                gidx  = IW'(j);
            end
        end
    end

    always_comb begin
        grant = '0;
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N; i++) begin
            if (gidx == IW'(i)) begin
                grant[i] = found;
                sel_a    = req_a[i*K +: K];
                sel_b    = req_b[i*K +: K];
            end
        end
    end

    assign req_ready = (state == IDLE && !rst) ? grant : '0;
    assign hs        = |(req_valid & req_ready);

`ifdef DIV_ARBITER_ZERO_CHECK_EN
    logic err_q;
    assign rsp_err  = err_q;
    assign zero_byp = (sel_b == '0);
`else
    assign rsp_err  = 1'b0;
    assign zero_byp = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (hs) begin
                    state_nxt = zero_byp ? RESP : ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (div_done) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered so they line up with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= IW'(N - 1);
            owner     <= '0;
            div_a     <= '0;
            div_b     <= '0;
            div_start <= 1'b0;
            rsp_valid <= '0;
            rsp_quo   <= '0;
            rsp_rem   <= '0;
`ifdef DIV_ARBITER_ZERO_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            div_start <= 1'b0;
            rsp_valid <= '0;
            if (state == IDLE && hs) begin
                div_a <= sel_a;
                div_b <= sel_b;
                owner <= gidx;
                ptr   <= gidx;
                if (zero_byp) begin
                    rsp_valid <= grant;
                    rsp_quo   <= '1;
                    rsp_rem   <= sel_a;
`ifdef DIV_ARBITER_ZERO_CHECK_EN
                    err_q     <= 1'b1;
`endif
                end else begin
                    div_start <= 1'b1;
                end
            end
            if (state == WAIT && div_done) begin
                rsp_valid <= ONE << owner;
                rsp_quo   <= div_quo;
                rsp_rem   <= div_rem;
`ifdef DIV_ARBITER_ZERO_CHECK_EN
                err_q     <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed table, corner sequences and random traffic
// against a round-robin/division reference model and a latency-driven divider model.
module tb_div_arbiter;

    localparam int K = 32;
    localparam int N = 3;
`ifdef DIV_ARBITER_ZERO_CHECK_EN
    localparam bit ZC = 1'b1;
`else
    localparam bit ZC = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*K-1:0] req_a;
    logic [N*K-1:0] req_b;
    logic [N-1:0]   rsp_valid;
    logic [K-1:0]   rsp_quo;
    logic [K-1:0]   rsp_rem;
    logic           rsp_err;
    logic           div_start;
    logic [K-1:0]   div_a;
    logic [K-1:0]   div_b;
    logic           div_done;
    logic [K-1:0]   div_quo;
    logic [K-1:0]   div_rem;

    div_arbiter #(.K(K), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_quo   (rsp_quo),
        .rsp_rem   (rsp_rem),
        .rsp_err   (rsp_err),
        .div_start (div_start),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_done  (div_done),
        .div_quo   (div_quo),
        .div_rem   (div_rem)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Divider model: answers D cycles after the start pulse.
    int          dlat = 4;
    bit          stray_req = 1'b0;
    int          dcnt = 0;
    logic [K-1:0] ca;
    logic [K-1:0] cb;

    initial begin
        div_done = 1'b0;
        div_quo  = '0;
        div_rem  = '0;
        forever begin
            @(posedge clk);
            #1;
            div_done = 1'b0;
            div_quo  = $urandom;
            div_rem  = $urandom;
            if (rst) begin
                dcnt = 0;
            end else if (stray_req) begin
                div_done  = 1'b1;
                stray_req = 1'b0;
            end else if (div_start) begin
                dcnt = dlat;
                ca   = div_a;
                cb   = div_b;
            end else if (dcnt > 0) begin
                check("div_a_hold", div_a, ca);
                check("div_b_hold", div_b, cb);
                dcnt--;
                if (dcnt == 0) begin
                    div_done = 1'b1;
                    div_quo  = (cb == 0) ? '1 : ca / cb;
                    div_rem  = (cb == 0) ? ca : ca % cb;
                end
            end
        end
    end

    // Reference model: grant = valid requester closest after the last owner.
    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int p);
        logic [N-1:0] g;
        int best;
        int bd;
        int d;
        g    = '0;
        best = -1;
        bd   = N;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                d = (i - p - 1 + N) % N;
                if (d < bd) begin
                    bd   = d;
                    best = i;
                end
            end
        end
        if (best >= 0) g[best] = 1'b1;
        return g;
    endfunction

    bit           busy, start_next, rsp_next, waiting, st_due, rsp_due;
    int           mptr, own, n_hs, n_rsp, n_start;
    int           wait_ops[N];
    logic [N-1:0] m_exp_rdy, m_hs;
    logic [K-1:0] oa, ob, eq, er;

    initial begin
        busy = 0; start_next = 0; rsp_next = 0; waiting = 0;
        mptr = N - 1; own = 0; n_hs = 0; n_rsp = 0; n_start = 0;
        for (int r = 0; r < N; r++) wait_ops[r] = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_ctl", {req_ready, rsp_valid, rsp_err, div_start}, '0);
                check("rst_rsp", {rsp_quo, rsp_rem}, '0);
                check("rst_div", {div_a, div_b}, '0);
                busy = 0; start_next = 0; rsp_next = 0; waiting = 0;
                mptr = N - 1; n_hs = 0; n_rsp = 0;
                for (int r = 0; r < N; r++) wait_ops[r] = 0;
            end else begin
                st_due     = start_next;
                start_next = 0;
                rsp_due    = rsp_next;
                rsp_next   = 0;
                m_exp_rdy  = busy ? '0 : rr_pick(req_valid, mptr);
                check("req_ready", req_ready, m_exp_rdy);
                check("div_start", div_start, st_due);
                if (div_start) n_start++;
                if (st_due) waiting = 1;
                check("rsp_valid", rsp_valid, rsp_due ? (N'(1) << own) : '0);
                if (rsp_due) begin
                    eq = (ob == 0) ? '1 : oa / ob;
                    er = (ob == 0) ? oa : oa % ob;
                    check("rsp_quo", rsp_quo, eq);
                    check("rsp_rem", rsp_rem, er);
                    check("rsp_err", rsp_err, ZC && (ob == 0));
                    busy = 0;
                    n_rsp++;
                end else if (waiting && div_done) begin
                    rsp_next = 1;
                    waiting  = 0;
                end
                for (int r = 0; r < N; r++) if (!req_valid[r]) wait_ops[r] = 0;
                m_hs = req_valid & m_exp_rdy;
                if (m_hs != '0) begin
                    for (int r = 0; r < N; r++) if (m_hs[r]) own = r;
                    for (int r = 0; r < N; r++) if (r != own && req_valid[r]) wait_ops[r]++;
                    check("fairness", wait_ops[own] < N, 1'b1);
                    wait_ops[own] = 0;
                    oa   = req_a[own*K +: K];
                    ob   = req_b[own*K +: K];
                    mptr = own;
                    busy = 1;
                    n_hs++;
                    if (ZC && ob == 0) rsp_next = 1;
                    else start_next = 1;
                end
            end
        end
    end

    task automatic send(input int r, input logic [K-1:0] a, input logic [K-1:0] b);
        bit ok;
        ok = 0;
        req_a[r*K +: K] = a;
        req_b[r*K +: K] = b;
        req_valid[r]    = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready[r]) begin
                ok = 1;
                break;
            end
        end
        check("accept", ok, 1'b1);
        @(posedge clk);
        #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output logic [N-1:0] v,
                            output logic [K-1:0] q, output logic [K-1:0] rm,
                            output logic e);
        lat = 0; v = '0; q = '0; rm = '0; e = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                lat = k; v = rsp_valid; q = rsp_quo; rm = rsp_rem; e = rsp_err;
                break;
            end
        end
        check("rsp_seen", lat > 0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit idle;
        idle = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            #1;
            if (!busy && req_valid == '0) begin
                idle = 1;
                break;
            end
        end
        check("drain_idle", idle, 1'b1);
        check("hs_vs_rsp", n_hs, n_rsp);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int           r;
        logic [K-1:0] a;
        logic [K-1:0] b;
        int           d;
        logic [K-1:0] q;
        logic [K-1:0] rm;
        logic         e;
        int           lat;
        int           starts;
    } vec_t;

    vec_t         tbl[6];
    int           lat, s0, got;
    int           exp_ord[4];
    bit           reassert, seen;
    logic [N-1:0] v, acc;
    logic [K-1:0] q, rm, ra, rb;
    logic         e;

    initial begin
        tbl[0] = '{1, 32'd100, 32'd7, 32, 32'd14, 32'd2, 1'b0, 34, 1};
        tbl[1] = '{0, 32'hFFFF_FFFF, 32'd1, 1, 32'hFFFF_FFFF, 32'd0, 1'b0, 3, 1};
        tbl[2] = '{2, 32'd5, 32'd9, 2, 32'd0, 32'd5, 1'b0, 4, 1};
        tbl[3] = '{1, 32'h1234, 32'd0, 3, 32'hFFFF_FFFF, 32'h1234, ZC, ZC ? 1 : 5, ZC ? 0 : 1};
        tbl[4] = '{0, 32'd1000000, 32'd1000, 5, 32'd1000, 32'd0, 1'b0, 7, 1};
        tbl[5] = '{2, 32'h8000_0000, 32'd3, 4, 32'h2AAA_AAAA, 32'd2, 1'b0, 6, 1};
        exp_ord = '{0, 1, 2, 0};

        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            dlat = tbl[i].d;
            s0   = n_start;
            send(tbl[i].r, tbl[i].a, tbl[i].b);
            wait_rsp(lat, v, q, rm, e);
            check("tbl_lat", lat, tbl[i].lat);
            check("tbl_onehot", v, N'(1) << tbl[i].r);
            check("tbl_quo", q, tbl[i].q);
            check("tbl_rem", rm, tbl[i].rm);
            check("tbl_err", e, tbl[i].e);
            check("tbl_starts", n_start - s0, tbl[i].starts);
        end

        // All three valid out of reset; requester 0 re-asserts once.
        rst = 1'b1;
        for (int r = 0; r < N; r++) begin
            req_a[r*K +: K] = 100 + r * 11;
            req_b[r*K +: K] = r + 3;
        end
        req_valid = '1;
        dlat = 2;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        reassert = 1;
        for (int g = 0; g < 4; g++) begin
            got = -1;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                for (int r = 0; r < N; r++) if (req_valid[r] && req_ready[r]) got = r;
                if (got >= 0) break;
            end
            check("rr_order", got, exp_ord[g]);
            @(posedge clk);
            #1;
            if (got == 0 && reassert) begin
                req_a[K-1:0] = 32'd4242;
                req_b[K-1:0] = 32'd6;
                reassert = 0;
            end else if (got >= 0) begin
                req_valid[got] = 1'b0;
            end else begin
                req_valid = '0;
            end
        end
        drain();

        // Operand and valid churn while the divider is busy.
        dlat = 20;
        send(2, 32'd777, 32'd10);
        repeat (3) @(posedge clk);
        #1;
        for (int c = 0; c < 10; c++) begin
            req_a[2*K +: K] = $urandom;
            req_b[2*K +: K] = $urandom;
            req_valid[0]    = 1'($urandom_range(0, 1));
            req_valid[1]    = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("stab_ready", req_ready, '0);
            check("stab_div_a", div_a, 32'd777);
            check("stab_div_b", div_b, 32'd10);
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        wait_rsp(lat, v, q, rm, e);
        check("stab_onehot", v, 3'b100);
        check("stab_quo", q, 32'd77);
        check("stab_rem", rm, 32'd7);
        drain();

        // Reset while waiting on the divider.
        dlat = 30;
        send(1, 32'd50, 32'd5);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_ctl", {req_ready, rsp_valid, rsp_err, div_start}, '0);
        check("arst_rsp", {rsp_quo, rsp_rem}, '0);
        check("arst_div", {div_a, div_b}, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) seen = 1;
            if (k == 5) stray_req = 1'b1;
        end
        check("dropped_rsp", seen, 1'b0);
        @(posedge clk);
        #1;
        dlat = 3;
        send(0, 32'd81, 32'd9);
        wait_rsp(lat, v, q, rm, e);
        check("post_rst_lat", lat, 5);
        check("post_rst_onehot", v, 3'b001);
        check("post_rst_quo", q, 32'd9);
        check("post_rst_rem", rm, 32'd0);

        // Random traffic; the monitor checks every cycle.
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            dlat = $urandom_range(1, 6);
            for (int r = 0; r < N; r++) begin
                if (acc[r]) begin
                    req_valid[r] = 1'b0;
                end else if (c < 600 && !req_valid[r] && $urandom_range(0, 2) == 0) begin
                    ra = $urandom;
                    if ($urandom_range(0, 7) == 0) rb = '0;
                    else if ($urandom_range(0, 1) == 1) rb = $urandom_range(1, 300);
                    else rb = $urandom;
                    req_a[r*K +: K] = ra;
                    req_b[r*K +: K] = rb;
                    req_valid[r]    = 1'b1;
                end
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
